// File: rtl/vita_tx_pkg.sv
// Shared definitions for the VITA-TX scheduler: FSM states, event codes,
// underflow/error policies and bit positions of the sample-line fields.
package vita_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [3:0] ERR_NONE     = 4'h0;
  localparam logic [3:0] ERR_EOB_ACK  = 4'h1;
  localparam logic [3:0] ERR_UNDERRUN = 4'h2;
  localparam logic [3:0] ERR_SEQ      = 4'h4;
  localparam logic [3:0] ERR_LATE     = 4'h8;

  localparam logic [1:0] POL_NEXT_PACKET = 2'd0;
  localparam logic [1:0] POL_NEXT_BURST  = 2'd1;
  localparam logic [1:0] POL_WAIT        = 2'd2;

  localparam int SAMPLES_LSB = 85;
  localparam int SEQERR_BIT  = 84;
  localparam int SEND_AT_BIT = 83;
  localparam int SOB_BIT     = 82;
  localparam int EOB_BIT     = 81;
  localparam int EOP_BIT     = 80;
  localparam int SEQ_LSB     = 64;
  localparam int TIME_LSB    = 0;

endpackage

// File: rtl/vita_tx_time_cmp.sv
// Unsigned 64-bit comparison of device time against a line timestamp.
module vita_tx_time_cmp (
  input  logic [63:0] vita_time,
  input  logic [63:0] line_time,
  output logic        now,
  output logic        late
);

  assign now  = (vita_time == line_time);
  assign late = (vita_time > line_time);

endmodule

// File: rtl/vita_tx_scheduler.sv
// Releases VITA-TX sample lines to the DSP chain on strobe, handling timed
// start, burst framing and error policy. Optional: VITA_TX_SCHED_ERRCNT_EN.
module vita_tx_scheduler
  import vita_tx_pkg::*;
#(
  parameter int BASE    = 0,
  parameter int MAXCHAN = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  input  logic [63:0]                 vita_time,
  input  logic [85+32*MAXCHAN-1:0]    sample_fifo_i,
  input  logic                        sample_src_rdy_i,
  output logic                        sample_dst_rdy_o,
  input  logic                        strobe_i,
  output logic [32*MAXCHAN-1:0]       sample_o,
  output logic                        run_o,
  output logic                        err_stb_o,
  output logic [3:0]                  err_code_o,
  output logic [3:0]                  err_seqnum_o,
  output logic [63:0]                 err_time_o,
  output logic [47:0]                 err_count_o
);

  localparam int W = 85 + 32*MAXCHAN;

  logic [1:0]  policy_q;
  logic        enable_q;
  logic [1:0]  pol;
  state_t      state_q, state_d;
  logic        pop, play, start_pkt;
  logic        ev_stb;
  logic [3:0]  ev_code, ev_seq;
  logic        last_eop_q;
  logic [3:0]  last_seq_q;
  logic        t_now, t_late;

  logic                  h_seqerr, h_send_at, h_eob, h_eop;
  logic [3:0]            h_seq;
  logic [63:0]           h_time;
  logic [32*MAXCHAN-1:0] h_samples;

  assign h_samples = sample_fifo_i[W-1:SAMPLES_LSB];
  assign h_seqerr  = sample_fifo_i[SEQERR_BIT];
  assign h_send_at = sample_fifo_i[SEND_AT_BIT];
  assign h_eob     = sample_fifo_i[EOB_BIT];
  assign h_eop     = sample_fifo_i[EOP_BIT];
  assign h_seq     = sample_fifo_i[SEQ_LSB+3:SEQ_LSB];
  assign h_time    = sample_fifo_i[TIME_LSB+63:TIME_LSB];

  logic unused_bits;
  assign unused_bits = ^{sample_fifo_i[SOB_BIT], sample_fifo_i[79:68], set_data[31:1]};

  vita_tx_time_cmp u_time_cmp (
    .vita_time (vita_time),
    .line_time (h_time),
    .now       (t_now),
    .late      (t_late)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      policy_q <= POL_NEXT_PACKET;
      enable_q <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))
        policy_q <= set_data[1:0];
      else if (set_addr == 8'(BASE + 1))
        enable_q <= set_data[0];
    end
  end

  // Policy code 3 behaves as NEXT_BURST.
  assign pol = (policy_q == 2'd3) ? POL_NEXT_BURST : policy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    start_pkt = 1'b0;
    ev_stb    = 1'b0;
    ev_code   = ERR_NONE;
    ev_seq    = h_seq;
    unique case (state_q)
      S_IDLE: begin
        if (enable_q && sample_src_rdy_i) begin
          start_pkt = 1'b1;
          if (h_seqerr) begin
            ev_stb = 1'b1; ev_code = ERR_SEQ; state_d = S_ERROR;
          end else if (h_send_at && t_late) begin
            ev_stb = 1'b1; ev_code = ERR_LATE; state_d = S_ERROR;
          end else if (h_send_at && !t_now) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_WAIT: begin
        if (sample_src_rdy_i && t_now) begin
          state_d = S_RUN;
        end else if (sample_src_rdy_i && t_late) begin
          ev_stb = 1'b1; ev_code = ERR_LATE; state_d = S_ERROR;
        end else if (!enable_q) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (strobe_i) begin
          if (sample_src_rdy_i) begin
            pop = 1'b1;
            if (h_seqerr) begin
              ev_stb = 1'b1; ev_code = ERR_SEQ; state_d = S_ERROR;
            end else if (h_eob && h_eop) begin
              ev_stb = 1'b1; ev_code = ERR_EOB_ACK; state_d = S_IDLE;
            end
          end else begin
            ev_stb  = 1'b1;
            ev_code = ERR_UNDERRUN;
            ev_seq  = last_seq_q;
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        if (pol == POL_NEXT_PACKET && last_eop_q) begin
          state_d = S_IDLE;
        end else if (sample_src_rdy_i) begin
          pop = 1'b1;
          if (pol == POL_NEXT_PACKET && h_eop)
            state_d = S_IDLE;
          else if (pol == POL_NEXT_BURST && h_eob && h_eop)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d   = S_IDLE;
      pop       = 1'b0;
      start_pkt = 1'b0;
      ev_stb    = 1'b0;
    end
  end

  assign sample_dst_rdy_o = pop;
  assign run_o            = (state_q == S_RUN);
  assign play             = pop && (state_q == S_RUN) && !h_seqerr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_o     <= '0;
      err_stb_o    <= 1'b0;
      err_code_o   <= ERR_NONE;
      err_seqnum_o <= '0;
      err_time_o   <= '0;
      last_eop_q   <= 1'b1;
      last_seq_q   <= '0;
    end else begin
      err_stb_o <= ev_stb;
      if (ev_stb) begin
        err_code_o   <= ev_code;
        err_seqnum_o <= ev_seq;
        err_time_o   <= vita_time;
      end
      // A new packet starts unpopped at the head, so its eop is still pending.
      if (pop) begin
        last_eop_q <= h_eop;
        last_seq_q <= h_seq;
      end else if (start_pkt) begin
        last_eop_q <= 1'b0;
      end
      if (play)
        sample_o <= h_samples;
      else if (strobe_i)
        sample_o <= '0;
    end
  end

`ifdef VITA_TX_SCHED_ERRCNT_EN
  logic [15:0] cnt_under_q, cnt_seq_q, cnt_late_q;
  logic        cnt_zero;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cnt_zero = set_stb && (set_addr == 8'(BASE + 1)) && set_data[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_under_q <= '0;
      cnt_seq_q   <= '0;
      cnt_late_q  <= '0;
    end else if (cnt_zero) begin
      cnt_under_q <= '0;
      cnt_seq_q   <= '0;
      cnt_late_q  <= '0;
    end else if (ev_stb) begin
      if (ev_code == ERR_UNDERRUN) cnt_under_q <= sat_inc(cnt_under_q);
      if (ev_code == ERR_SEQ)      cnt_seq_q   <= sat_inc(cnt_seq_q);
      if (ev_code == ERR_LATE)     cnt_late_q  <= sat_inc(cnt_late_q);
    end
  end

  assign err_count_o = {cnt_late_q, cnt_seq_q, cnt_under_q};
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_vita_tx_scheduler.sv
// Directed-random bench for vita_tx_scheduler: a line FIFO model feeds the
// DUT and each burst scenario's expected output is derived from its lines.
module tb_vita_tx_scheduler;

  localparam int MAXCHAN = 1;
  localparam int W       = 85 + 32*MAXCHAN;
  localparam int BASE    = 0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         set_stb = 1'b0;
  logic [7:0]   set_addr = '0;
  logic [31:0]  set_data = '0;
  logic [63:0]  vt = 64'd0;
  logic [W-1:0] sample_fifo_i;
  logic         sample_src_rdy_i;
  logic         sample_dst_rdy_o;
  logic         strobe_i = 1'b0;
  logic [31:0]  sample_o;
  logic         run_o, err_stb_o;
  logic [3:0]   err_code_o, err_seqnum_o;
  logic [63:0]  err_time_o;
  logic [47:0]  err_count_o;

  logic [W-1:0] mem [0:255];
  logic [7:0]   wr_ptr = '0;
  logic [7:0]   rd_ptr = '0;
  int           ev_cnt = 0;
  int           tests = 0;
  int           fails = 0;
  int           exp_late = 0, exp_seq = 0, exp_under = 0;

  assign sample_src_rdy_i = (rd_ptr != wr_ptr);
  assign sample_fifo_i    = mem[rd_ptr];

  vita_tx_scheduler #(.BASE(BASE), .MAXCHAN(MAXCHAN)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear            (clear),
    .set_stb          (set_stb),
    .set_addr         (set_addr),
    .set_data         (set_data),
    .vita_time        (vt),
    .sample_fifo_i    (sample_fifo_i),
    .sample_src_rdy_i (sample_src_rdy_i),
    .sample_dst_rdy_o (sample_dst_rdy_o),
    .strobe_i         (strobe_i),
    .sample_o         (sample_o),
    .run_o            (run_o),
    .err_stb_o        (err_stb_o),
    .err_code_o       (err_code_o),
    .err_seqnum_o     (err_seqnum_o),
    .err_time_o       (err_time_o),
    .err_count_o      (err_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_src_rdy_i && sample_dst_rdy_o) rd_ptr <= rd_ptr + 8'd1;
    if (err_stb_o) ev_cnt <= ev_cnt + 1;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] smp, input bit seqerr, input bit send_at,
                      input bit sob, input bit eob, input bit eop,
                      input logic [3:0] seq, input logic [63:0] t);
    logic [W-1:0] l;
    l = '0;
    l[W-1:85] = smp;
    l[84] = seqerr; l[83] = send_at; l[82] = sob; l[81] = eob; l[80] = eop;
    l[67:64] = seq;
    l[63:0]  = t;
    mem[wr_ptr] = l;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic set_reg(input int addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = 8'(addr); set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic strobe();
    strobe_i = 1'b1;
    tick();
    strobe_i = 1'b0;
  endtask

  function automatic logic [7:0] fifo_cnt();
    return wr_ptr - rd_ptr;
  endfunction

  function automatic logic [31:0] rnd_smp();
    return $urandom | 32'h1;
  endfunction

  logic [31:0] smp [0:3];
  logic [3:0]  sq;
  logic [63:0] t0;
  int          ev0;

  initial begin
    // Reset state
    tick(3);
    check("rst_run", 64'(run_o), 64'd0);
    check("rst_sample", 64'(sample_o), 64'd0);
    check("rst_errstb", 64'(err_stb_o), 64'd0);
    check("rst_code", 64'(err_code_o), 64'd0);
    check("rst_pop", 64'(sample_dst_rdy_o), 64'd0);
    check("rst_count", 64'(err_count_o), 64'd0);
    reset_n = 1'b1;
    tick();
    set_reg(BASE + 1, 32'd1);

    // Plain 3-line burst
    sq = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      smp[i] = rnd_smp();
      push(smp[i], 0, 0, i == 0, i == 2, i == 2, sq + 4'(i), 64'd0);
    end
    tick();
    check("burst_run", 64'(run_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      strobe();
      check($sformatf("burst_smp%0d", i), 64'(sample_o), 64'(smp[i]));
    end
    check("burst_ack_stb", 64'(err_stb_o), 64'd1);
    check("burst_ack_code", 64'(err_code_o), 64'd1);
    check("burst_ack_seq", 64'(err_seqnum_o), 64'(sq + 4'd2));
    check("burst_idle", 64'(run_o), 64'd0);
    tick();
    check("burst_stb_1cyc", 64'(err_stb_o), 64'd0);
    check("burst_fifo_empty", 64'(fifo_cnt()), 64'd0);

    // Timed start in the future
    t0 = 64'd1000 + 64'($urandom_range(0, 5000));
    vt = t0 - 64'd100;
    ev0 = ev_cnt;
    smp[0] = rnd_smp(); sq = 4'($urandom);
    push(smp[0], 0, 1, 1, 1, 1, sq, t0);
    tick(3);
    check("wait_no_run", 64'(run_o), 64'd0);
    check("wait_no_pop", 64'(fifo_cnt()), 64'd1);
    vt = t0;
    tick(2);
    check("wait_run", 64'(run_o), 64'd1);
    check("wait_no_err", 64'(ev_cnt), 64'(ev0));
    strobe();
    check("wait_smp", 64'(sample_o), 64'(smp[0]));
    check("wait_ack", 64'(err_code_o), 64'd1);

    // Late start, NEXT_PACKET drops through eop
    vt = 64'd900 + 64'($urandom_range(0, 1000));
    sq = 4'($urandom);
    push(rnd_smp(), 0, 1, 1, 0, 0, sq, vt - 64'd400);
    push(rnd_smp(), 0, 0, 0, 0, 1, sq + 4'd1, 64'd0);
    smp[0] = rnd_smp();
    push(smp[0], 0, 0, 1, 1, 1, sq + 4'd2, 64'd0);
    tick();
    exp_late++;
    check("late_stb", 64'(err_stb_o), 64'd1);
    check("late_code", 64'(err_code_o), 64'd8);
    check("late_time", err_time_o, vt);
    check("late_seq", 64'(err_seqnum_o), 64'(sq));
    tick(4);
    check("late_next_run", 64'(run_o), 64'd1);
    check("late_dropped", 64'(fifo_cnt()), 64'd1);
    strobe();
    check("late_next_smp", 64'(sample_o), 64'(smp[0]));
    check("late_next_ack", 64'(err_seqnum_o), 64'(sq + 4'd2));

    // Underrun mid-burst, NEXT_BURST
    set_reg(BASE, 32'd1);
    sq = 4'($urandom);
    smp[0] = rnd_smp(); smp[1] = rnd_smp();
    push(smp[0], 0, 0, 1, 0, 0, sq, 64'd0);
    push(smp[1], 0, 0, 0, 0, 1, sq + 4'd1, 64'd0);
    tick();
    strobe();
    check("und_smp0", 64'(sample_o), 64'(smp[0]));
    strobe();
    check("und_smp1", 64'(sample_o), 64'(smp[1]));
    strobe();
    exp_under++;
    check("und_stb", 64'(err_stb_o), 64'd1);
    check("und_code", 64'(err_code_o), 64'd2);
    check("und_zero", 64'(sample_o), 64'd0);
    push(rnd_smp(), 0, 0, 0, 0, 0, sq + 4'd2, 64'd0);
    push(rnd_smp(), 0, 0, 0, 1, 1, sq + 4'd3, 64'd0);
    smp[2] = rnd_smp();
    push(smp[2], 0, 0, 1, 1, 1, sq + 4'd4, 64'd0);
    tick(4);
    check("und_next_run", 64'(run_o), 64'd1);
    check("und_dropped", 64'(fifo_cnt()), 64'd1);
    strobe();
    check("und_next_smp", 64'(sample_o), 64'(smp[2]));
    check("und_next_ack", 64'(err_seqnum_o), 64'(sq + 4'd4));

    // Sequence error, WAIT policy holds until clear
    set_reg(BASE, 32'd2);
    sq = 4'($urandom);
    push(rnd_smp(), 1, 0, 1, 0, 0, sq, 64'd0);
    push(rnd_smp(), 0, 0, 0, 0, 0, sq + 4'd1, 64'd0);
    push(rnd_smp(), 0, 0, 0, 1, 1, sq + 4'd2, 64'd0);
    tick();
    exp_seq++;
    check("seq_code", 64'(err_code_o), 64'd4);
    check("seq_seq", 64'(err_seqnum_o), 64'(sq));
    ev0 = ev_cnt;
    tick(5);
    push(rnd_smp(), 0, 0, 1, 1, 1, sq + 4'd3, 64'd0);
    tick(3);
    check("seq_all_dropped", 64'(fifo_cnt()), 64'd0);
    check("seq_no_run", 64'(run_o), 64'd0);
    check("seq_no_more_ev", 64'(ev_cnt), 64'(ev0 + 1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_reg(BASE, 32'd0);
    smp[0] = rnd_smp();
    push(smp[0], 0, 0, 1, 1, 1, sq + 4'd4, 64'd0);
    tick(2);
    check("seq_clear_run", 64'(run_o), 64'd1);
    strobe();
    check("seq_clear_smp", 64'(sample_o), 64'(smp[0]));

    // Error counters
`ifdef VITA_TX_SCHED_ERRCNT_EN
    check("cnt_before", 64'(err_count_o),
          64'({16'(exp_late), 16'(exp_seq), 16'(exp_under)}));
`else
    check("cnt_tied", 64'(err_count_o), 64'd0);
`endif
    set_reg(BASE + 1, 32'd3);
    check("cnt_zeroed", 64'(err_count_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      smp[0] = rnd_smp();
      push(smp[0], 0, 0, 1, 0, 1, 4'(i), 64'd0);
      tick();
      strobe();
      check($sformatf("cnt_smp%0d", i), 64'(sample_o), 64'(smp[0]));
      strobe();
      check($sformatf("cnt_und%0d", i), 64'(err_code_o), 64'd2);
      tick(2);
    end
`ifdef VITA_TX_SCHED_ERRCNT_EN
    check("cnt_three", 64'(err_count_o), 64'd3);
`else
    check("cnt_three_tied", 64'(err_count_o), 64'd0);
`endif
    set_reg(BASE + 1, 32'd3);
    check("cnt_rezeroed", 64'(err_count_o), 64'd0);

    // Reset in the middle of a burst
    smp[0] = rnd_smp();
    push(smp[0], 0, 0, 1, 0, 0, 4'd9, 64'd0);
    tick();
    strobe();
    check("rstm_smp", 64'(sample_o), 64'(smp[0]));
    push(rnd_smp(), 0, 0, 0, 1, 1, 4'd10, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rstm_run", 64'(run_o), 64'd0);
    check("rstm_sample", 64'(sample_o), 64'd0);
    check("rstm_code", 64'(err_code_o), 64'd0);
    check("rstm_pop", 64'(sample_dst_rdy_o), 64'd0);
    tick();
    reset_n = 1'b1;
    tick(3);
    check("rstm_fifo_kept", 64'(fifo_cnt()), 64'd1);
    check("rstm_disabled", 64'(run_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
